// File: rtl/onehot_window_monitor.sv
// Window statistics for a 4-bit one-hot decoder output: per-line hit counts plus a
// multi-hot error count, reported as five tagged words over valid/ready at each window end.
module onehot_window_monitor #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned CW     = 8
) (
    input  logic          uclk,
    input  logic          urst,
    input  logic          en,
    input  logic [3:0]    y_in,
    output logic [CW-1:0] out_data,
    output logic [2:0]    out_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    output logic          busy
);

    localparam int unsigned   WW       = 16;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] win_q, win_d;
    logic [CW-1:0] hit_q [4];
    logic [CW-1:0] hit_d [4];
    logic [CW-1:0] err_q, err_d;
    logic [CW-1:0] snap  [5];
    logic [CW-1:0] rep_q [5];
    logic [CW-1:0] rep_d [5];
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] data_q, data_d;
    logic          overrun_q, overrun_d;
    logic          multi, single, term;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign multi  = |(y_in & (y_in - 4'd1));
    assign single = (y_in != 4'd0) && !multi;
    assign term   = en && (win_q == WIN_LAST);

    // Snapshot includes the current sample so the terminal cycle is not lost.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            snap[k] = hit_q[k];
            if (single && y_in[k] && (hit_q[k] != CNT_MAX)) begin
                snap[k] = hit_q[k] + CNT_ONE;
            end
        end
        snap[4] = err_q;
        if (multi && (err_q != CNT_MAX)) begin
            snap[4] = err_q + CNT_ONE;
        end
    end

    always_comb begin
        win_d     = win_q;
        hit_d     = hit_q;
        err_d     = err_q;
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        if (en) begin
            if (term) begin
                win_d = '0;
                for (int k = 0; k < 4; k++) begin
                    hit_d[k] = '0;
                end
                err_d = '0;
            end else begin
                win_d = win_q + 16'd1;
                for (int k = 0; k < 4; k++) begin
                    hit_d[k] = snap[k];
                end
                err_d = snap[4];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (term) begin
                    rep_d   = snap;
                    state_d = StSend;
                    idx_d   = 3'd0;
                    data_d  = snap[0];
                end
            end
            StSend: begin
                // A window ending while a report is in flight is dropped, not queued.
                if (term) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    if (idx_q == 3'd4) begin
                        state_d = StIdle;
                        idx_d   = 3'd0;
                        data_d  = '0;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = rep_q[idx_d];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge uclk) begin
        if (urst) begin
            state_q   <= StIdle;
            win_q     <= '0;
            for (int k = 0; k < 4; k++) begin
                hit_q[k] <= '0;
            end
            err_q     <= '0;
            for (int k = 0; k < 5; k++) begin
                rep_q[k] <= '0;
            end
            idx_q     <= 3'd0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            hit_q     <= hit_d;
            err_q     <= err_d;
            rep_q     <= rep_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_tag   = idx_q;
    assign out_valid = (state_q == StSend);
    assign busy      = (state_q == StSend);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_onehot_window_monitor.sv
// Bench for onehot_window_monitor: table of windows checked through an expected-word queue,
// plus hand sequences for backpressure, enable gating, overrun, saturation and reset.
module tb_onehot_window_monitor;

    logic       uclk = 1'b0;
    logic       urst, en, out_ready;
    logic [3:0] y_in;

    logic [7:0] out_data;
    logic [2:0] out_tag;
    logic       out_valid, overrun, busy;
    logic [7:0] d5_data;
    logic [2:0] d5_tag;
    logic       d5_valid, d5_overrun, d5_busy;
    logic [2:0] ds_data;
    logic [2:0] ds_tag;
    logic       ds_valid, ds_overrun, ds_busy;

    onehot_window_monitor #(.WINDOW(8), .CW(8)) dut (
        .uclk(uclk), .urst(urst), .en(en), .y_in(y_in), .out_data(out_data),
        .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .busy(busy)
    );
    onehot_window_monitor #(.WINDOW(5), .CW(8)) dut5 (
        .uclk(uclk), .urst(urst), .en(en), .y_in(y_in), .out_data(d5_data),
        .out_tag(d5_tag), .out_valid(d5_valid), .out_ready(out_ready),
        .overrun(d5_overrun), .busy(d5_busy)
    );
    onehot_window_monitor #(.WINDOW(8), .CW(3)) dut_sat (
        .uclk(uclk), .urst(urst), .en(en), .y_in(y_in), .out_data(ds_data),
        .out_tag(ds_tag), .out_valid(ds_valid), .out_ready(out_ready),
        .overrun(ds_overrun), .busy(ds_busy)
    );

    always #5 uclk = ~uclk;

    typedef struct packed {
        logic [31:0] ys;   // sample i in ys[4*i +: 4]
        logic [39:0] exp;  // word k in exp[8*k +: 8]
    } vec_t;

    vec_t        tbl [4];
    logic [10:0] exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Falling edge: score any accepted word against the queue; then step past the rising edge.
    task automatic tick();
        logic [10:0] e;
        @(negedge uclk);
        if (mon_en && !urst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL word_unexpected actual=%0d:%0h required=none", out_tag, out_data);
            end else begin
                e = exp_q.pop_front();
                check("word", {out_tag, out_data}, {21'd0, e});
            end
        end
        @(posedge uclk);
        #1;
    endtask

    task automatic push_words(input logic [39:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({3'(k), w[8*k +: 8]});
        end
    endtask

    task automatic run_window(input logic [31:0] ys, input logic rdy, input logic lat);
        for (int i = 0; i < 8; i++) begin
            en        = 1'b1;
            y_in      = ys[4*i +: 4];
            out_ready = rdy;
            tick();
            if (lat && i == 6) check("pre_term_valid", 32'(out_valid), 32'd0);
            if (lat && i == 7) check("term_latency", {28'd0, out_valid, out_tag}, {28'd0, 4'b1000});
        end
        en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        en        = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        urst = 1'b1;
        en   = 1'b0;
        tick();
        urst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{ys: 32'h0888_4221, exp: 40'h00_03_01_02_01};
        tbl[1] = '{ys: 32'h0000_1F33, exp: 40'h03_00_00_00_01};
        tbl[2] = '{ys: 32'h2205_1248, exp: 40'h01_01_01_03_01};
        tbl[3] = '{ys: 32'hF753_9AC6, exp: 40'h08_00_00_00_00};

        urst = 1'b1; en = 1'b0; y_in = 4'd0; out_ready = 1'b1;
        do_reset();
        check("reset_state", {19'd0, out_valid, busy, overrun, out_tag, out_data}, 32'd0);
        mon_en = 1'b1;

        // Table-driven windows, each drained before the next.
        for (int t = 0; t < 4; t++) begin
            push_words(tbl[t].exp, 5);
            run_window(tbl[t].ys, 1'b1, 1'b1);
            drain();
            check("no_overrun", 32'(overrun), 32'd0);
        end

        // Backpressure: tag 0 must hold for 10 stalled cycles.
        push_words(tbl[0].exp, 5);
        run_window(tbl[0].ys, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold", {20'd0, out_valid, out_tag, out_data}, {20'd0, 1'b1, 3'd0, 8'd1});
        end
        drain();

        // Enable gating: 7 samples, 20 disabled cycles of junk, then the 8th sample.
        push_words(40'h00_00_03_04_00, 5);
        for (int i = 0; i < 7; i++) begin
            en = 1'b1; y_in = (i < 4) ? 4'h2 : 4'h4; tick();
        end
        en = 1'b0; y_in = 4'hF;
        for (int c = 0; c < 20; c++) tick();
        check("gated_no_term", 32'(out_valid), 32'd0);
        en = 1'b1; y_in = 4'h0; tick();
        check("gated_term", 32'(out_valid), 32'd1);
        drain();

        // Overrun part A: second window ends while the first report is stalled.
        push_words(tbl[0].exp, 5);
        run_window(tbl[0].ys, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; y_in = 4'h1; out_ready = 1'b0; tick();
            if (i == 6) check("ovr_before", 32'(overrun), 32'd0);
        end
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_rep_kept", {21'd0, out_tag, out_data}, {21'd0, 3'd0, 8'd1});
        en = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        drain();
        push_words(tbl[2].exp, 5);
        run_window(tbl[2].ys, 1'b1, 1'b1);
        drain();
        check("ovr_sticky", 32'(overrun), 32'd1);

        // Reset during the tag-2 word; samples taken meanwhile must be discarded.
        push_words(tbl[0].exp, 2);
        run_window(tbl[0].ys, 1'b1, 1'b0);
        en = 1'b1; y_in = 4'h8; tick();
        tick();
        check("tag2_pending", 32'(out_tag), 32'd2);
        urst = 1'b1; tick();
        urst = 1'b0; en = 1'b0;
        check("mid_rst", {19'd0, out_valid, busy, overrun, out_tag, out_data}, 32'd0);
        check("mid_rst_q", 32'(exp_q.size()), 32'd0);
        push_words(tbl[1].exp, 5);
        run_window(tbl[1].ys, 1'b1, 1'b1);
        drain();

        // Overrun part B on WINDOW=5 with the consumer always ready.
        mon_en = 1'b0;
        do_reset();
        en = 1'b1; y_in = 4'h1; out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                check("w5_first", {20'd0, d5_valid, d5_tag, d5_data}, {20'd0, 1'b1, 3'd0, 8'd5});
                check("w5_first_ovr", 32'(d5_overrun), 32'd0);
            end
            if (i == 9) check("w5_pre_ovr", 32'(d5_overrun), 32'd0);
        end
        check("w5_ovr", 32'(d5_overrun), 32'd1);

        // Saturation with CW=3.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            en = 1'b1; y_in = 4'h1; tick();
        end
        en = 1'b0;
        check("sat", {26'd0, ds_valid, ds_tag, ds_data}, {26'd0, 1'b1, 3'd0, 3'd7});
        tick();
        check("sat_tag1", {26'd0, ds_tag, ds_data}, {26'd0, 3'd1, 3'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onehot_window_monitor.md
# onehot_window_monitor

Downstream consumer of the mux/decoder stage's 4-bit one-hot output. Over a fixed window of enabled cycles it counts how often each of the four decoder lines is active and how often an illegal multi-hot code appears. At each window end it snapshots the counts and reports them as five tagged words over a valid/ready handshake, for capture by the ILA or a host-side reader.

## Interface
Parameters:
- WINDOW, default 256: number of enabled sample cycles per window; legal range 2..65535.
- CW, default 8: width of each count and of the report word.

Ports:
- uclk  input  1  system clock; all logic on the rising edge.
- urst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; when low, the window counter and live counters hold.
- y_in  input  4  one-hot line from the decoder stage.
- out_data  output  CW  report word.
- out_tag  output  3  word index: 0–3 are channel counts, 4 is the error count.
- out_valid  output  1  out_data and out_tag are valid.
- out_ready  input  1  consumer accepts the word when high together with out_valid.
- overrun  output  1  sticky flag: a window ended while a report was still in progress.
- busy  output  1  report FSM is not in IDLE.

## Operation
- **Live counters:** hit[0..3] and err, each CW bits wide and saturating at 2^CW−1.
- **Per sample** (each cycle with en=1):
  - exactly one bit of y_in set → the matching hit[k] increments;
  - two or more bits set → err increments and no hit counter changes;
  - y_in=0 → nothing increments.
- **Window counter:**
  - runs 0..WINDOW−1 and advances only when en=1.
  - The terminal cycle is a cycle with en=1 and count = WINDOW−1.
  - On the terminal cycle the counter wraps to 0.
- **On the terminal cycle:**
  - The snapshot equals the live counters *including* the terminal cycle's own sample (saturation still applies).
  - All live counters load 0 for the next cycle. No sample is lost or double-counted across the boundary.
  - If the FSM is in IDLE: load the snapshot into the report registers and go to SEND with idx=0.
  - If the FSM is not in IDLE: discard the snapshot, set overrun=1, and leave the report in progress untouched.
- **Report FSM:**
  - **IDLE:** out_valid=0.
  - **SEND:**
    - out_valid=1, out_tag=idx, out_data=rep[idx].
    - On out_valid & out_ready: if idx=4, go to IDLE; otherwise increment idx.
    - While out_ready=0, out_data and out_tag hold stable and out_valid stays 1.
- overrun clears only on urst.
- en has no effect on the FSM; a report drains while en=0.
- **Reset** (urst=1 at a rising edge, including mid-report):
  - window counter, live counters, report registers and idx → 0; FSM → IDLE;
  - out_valid=0, out_tag=0, out_data=0, overrun=0, busy=0.
  - A word that was pending is dropped.
  - urst takes priority over en and over a terminal cycle occurring in the same cycle.

## Timing
- All outputs are registered.
- **Latency:** terminal cycle at edge N → out_valid=1 with tag 0 after edge N+1.
- With out_ready held at 1, one word is transferred per cycle: a report takes 5 cycles, and busy falls after the 5th transfer.
- A terminal cycle in the same cycle as the final (tag 4) handshake counts as an overrun, because the FSM is not yet in IDLE.
- Minimum window is 2 cycles, which is shorter than a report. This is legal and yields overrun when the consumer is slow.
- Back-to-back reports with no overrun require WINDOW ≥ 6 and out_ready held at 1.

## Test plan
Benches use WINDOW=8 and CW=8 unless stated otherwise.

1. **Single window.** Reset, then en=1 and y_in sequence 1,2,2,4,8,8,8,0 with out_ready=1 → words (tag,data) = (0,1), (1,2), (2,1), (3,3), (4,0); out_valid appears 1 cycle after the 8th sample; overrun=0.
2. **Illegal codes and zeros.** Window with y_in = 3,3,F,1,0,0,0,0 → tag0=1, tag4=3, tags1–3=0.
3. **Backpressure and enable gating.**
   - Hold out_ready=0 for 10 cycles during SEND → tag 0 word stays stable with out_valid=1 throughout.
   - With en=0 for 20 cycles mid-window, y_in is ignored and the window completes only after 8 enabled cycles.
4. **Overrun.**
   - Part A: WINDOW=8, out_ready=0 for 12 cycles after the first report starts → overrun=1 at the second terminal cycle; the first report's data is unchanged; the third window reports normally after drain.
   - Part B: WINDOW=5, out_ready=1 → overrun sets on every window after the first.
5. **Saturation.** CW=3 with y_in=1 for all 8 samples → tag0=7.
6. **Reset mid-report.** Assert urst during tag-2 SEND → next cycle out_valid=0, busy=0, overrun=0; the following window counts from 0.
